// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit execute-stage ALU: opcodes, width and the
// bundled result/flag type passed from the combinational core to the register.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0] res;
    logic             carry;
    logic             zero;
    logic             ovf;
  } alu_res_t;

  localparam alu_res_t ALU_RESET = '{res: '0, carry: 1'b0, zero: 1'b1, ovf: 1'b0};

  function automatic logic is_zero(input logic [ALU_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: decodes sel and produces the next result and flags.
// A 5-bit internal path captures the carry out of ADD and the borrow of SUB.
module alu_comb
  import alu_pkg::*;
(
  input  logic [2:0]       sel,
  input  logic [ALU_W-1:0] IN0,
  input  logic [ALU_W-1:0] IN1,
  output alu_res_t         nxt
);

  logic [ALU_W:0] sum;
  logic [ALU_W:0] diff;

  assign sum  = {1'b0, IN0} + {1'b0, IN1};
  assign diff = {1'b0, IN0} - {1'b0, IN1};

  always_comb begin
    nxt = '0;
    unique case (sel)
      OP_ADD: begin
        nxt.res   = sum[ALU_W-1:0];
        nxt.carry = sum[ALU_W];
        nxt.ovf   = (IN0[ALU_W-1] == IN1[ALU_W-1]) && (sum[ALU_W-1] != IN0[ALU_W-1]);
      end
      OP_SUB: begin
        // diff[4] is set exactly when IN0 < IN1 unsigned, i.e. the borrow
        nxt.res   = diff[ALU_W-1:0];
        nxt.carry = diff[ALU_W];
        nxt.ovf   = (IN0[ALU_W-1] != IN1[ALU_W-1]) && (diff[ALU_W-1] != IN0[ALU_W-1]);
      end
      OP_AND: nxt.res = IN0 & IN1;
      OP_OR:  nxt.res = IN0 | IN1;
      OP_XOR: nxt.res = IN0 ^ IN1;
      OP_NOT: nxt.res = ~IN0;
      OP_SHL: begin
        nxt.res   = {IN0[ALU_W-2:0], 1'b0};
        nxt.carry = IN0[ALU_W-1];
      end
      OP_SHR: begin
        nxt.res   = {1'b0, IN0[ALU_W-1:1]};
        nxt.carry = IN0[0];
      end
      default: nxt = '0;
    endcase
    nxt.zero = is_zero(nxt.res);
  end

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: registers the result and flags from alu_comb each clock.
// No handshake: one operation is sampled on every rising clk, visible after that edge.
module alu_unit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic [ALU_W-1:0] IN0,
  input  logic [ALU_W-1:0] IN1,
  output logic [ALU_W-1:0] OUT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             OVF
);

  alu_res_t nxt;
  alu_res_t q;

  alu_comb u_comb (
    .sel (sel),
    .IN0 (IN0),
    .IN1 (IN1),
    .nxt (nxt)
  );

  // Flags and result share one register so ZERO always matches the OUT beside it.
  always_ff @(posedge clk) begin
    if (rst) q <= ALU_RESET;
    else     q <= nxt;
  end

  assign OUT   = q.res;
  assign CARRY = q.carry;
  assign ZERO  = q.zero;
  assign OVF   = q.ovf;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit with hand-computed expected results and flags.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic [3:0] in0, in1;
  logic [3:0] out;
  logic       carry, zero, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  alu_unit dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .IN0   (in0),
    .IN1   (in1),
    .OUT   (out),
    .CARRY (carry),
    .ZERO  (zero),
    .OVF   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_out,
                           input logic e_c, input logic e_z, input logic e_v);
    check({tag, ".out"},   {4'b0, out},   {4'b0, e_out});
    check({tag, ".carry"}, {7'b0, carry}, {7'b0, e_c});
    check({tag, ".zero"},  {7'b0, zero},  {7'b0, e_z});
    check({tag, ".ovf"},   {7'b0, ovf},   {7'b0, e_v});
  endtask

  // Drive at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic apply(input logic r, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst = r; sel = s; in0 = a; in1 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = 3'b000; in0 = 4'h0; in1 = 4'h0;

    // Reset held for two cycles with arbitrary operands
    apply(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    check_all("reset0", 4'b0000, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    check_all("reset1", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Opcode sweep, IN0=0101 IN1=0011, back-to-back
    apply(1'b0, 3'b000, 4'b0101, 4'b0011); check_all("sw_add", 4'b1000, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 3'b001, 4'b0101, 4'b0011); check_all("sw_sub", 4'b0010, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'b010, 4'b0101, 4'b0011); check_all("sw_and", 4'b0001, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'b011, 4'b0101, 4'b0011); check_all("sw_or",  4'b0111, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'b100, 4'b0101, 4'b0011); check_all("sw_xor", 4'b0110, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'b101, 4'b0101, 4'b0011); check_all("sw_not", 4'b1010, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'b110, 4'b0101, 4'b0011); check_all("sw_shl", 4'b1010, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'b111, 4'b0101, 4'b0011); check_all("sw_shr", 4'b0010, 1'b1, 1'b0, 1'b0);

    // Carry / zero / overflow boundaries
    apply(1'b0, 3'b000, 4'b1111, 4'b0001); check_all("add_wrap", 4'b0000, 1'b1, 1'b1, 1'b0);
    // Outputs must hold between edges even though inputs already changed
    @(negedge clk);
    sel = 3'b001; in0 = 4'b0011; in1 = 4'b0101;
    #1;
    check_all("hold", 4'b0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_all("sub_borrow", 4'b1110, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 3'b001, 4'b1000, 4'b0001); check_all("sub_ovf",  4'b0111, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 3'b000, 4'b0111, 4'b0001); check_all("add_ovf",  4'b1000, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 3'b001, 4'b0000, 4'b0000); check_all("sub_zero", 4'b0000, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 3'b110, 4'b1001, 4'b0000); check_all("shl_c",    4'b0010, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 3'b010, 4'b1010, 4'b0101); check_all("and_zero", 4'b0000, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 3'b101, 4'b1111, 4'b0110); check_all("not_zero", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset discards the in-flight ADD, then the stream resumes
    apply(1'b0, 3'b111, 4'b0101, 4'b0011); check_all("pre_rst",  4'b0010, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 3'b000, 4'b0101, 4'b0011); check_all("mid_rst",  4'b0000, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 3'b111, 4'b0101, 4'b0011); check_all("post_rst", 4'b0010, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 3'b000, 4'b0101, 4'b0011); check_all("post_add", 4'b1000, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
